// File: rtl/colour_dispatch.sv
// Colour-sensor chip sorter controller: samples R/G/B pulse counts, classifies the chip,
// dispatches a colour code to the sorter and issues a lift request every LIFT_EVERY chips.
module colour_dispatch #(
    parameter int unsigned GATE_CYCLES    = 1000000,
    parameter int unsigned SETTLE_CYCLES  = 5000,
    parameter int unsigned DARK_TH        = 200,
    parameter int unsigned WHITE_TH       = 2000,
    parameter int unsigned DOM_MARGIN     = 50,
    parameter int unsigned LIFT_EVERY     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sensorOut,
    input  logic       complete,
    output logic       s2,
    output logic       s3,
    output logic [2:0] colour,
    output logic       start,
    output logic       timeoutErr
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SELECT   = 4'd1;
    localparam logic [3:0] S_SETTLE   = 4'd2;
    localparam logic [3:0] S_GATE     = 4'd3;
    localparam logic [3:0] S_CLASSIFY = 4'd4;
    localparam logic [3:0] S_DISPATCH = 4'd5;
    localparam logic [3:0] S_ARM      = 4'd6;
    localparam logic [3:0] S_WAITDONE = 4'd7;
    localparam logic [3:0] S_RELEASE  = 4'd8;

    localparam logic [2:0] C_RED     = 3'b000;
    localparam logic [2:0] C_GREEN   = 3'b001;
    localparam logic [2:0] C_BLUE    = 3'b010;
    localparam logic [2:0] C_BIN     = 3'b011;
    localparam logic [2:0] C_RECYCLE = 3'b100;
    localparam logic [2:0] C_LIFT    = 3'b101;
    localparam logic [2:0] C_IDLE    = 3'b111;

    localparam logic [31:0] L_SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] L_GATE_LAST    = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] L_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] L_DARK         = 32'(DARK_TH);
    localparam logic [31:0] L_WHITE        = 32'(WHITE_TH);
    localparam logic [31:0] L_MARGIN       = 32'(DOM_MARGIN);
    localparam logic [31:0] L_LIFT         = 32'(LIFT_EVERY);

    logic [3:0]  r_state;
    logic [1:0]  r_chan;
    logic [31:0] r_timer;
    logic [31:0] r_chips;
    logic [15:0] r_count;
    logic [15:0] r_red;
    logic [15:0] r_green;
    logic [15:0] r_blue;
    logic [2:0]  r_colour;
    logic        r_lift;
    logic        r_s2;
    logic        r_s3;
    logic        r_start;
    logic        r_timeout;
    logic        r_sens_meta;
    logic        r_sens_sync;
    logic        r_sens_prev;

    logic        w_pulse;
    logic [15:0] w_count_next;
    logic [31:0] w_red;
    logic [31:0] w_green;
    logic [31:0] w_blue;
    logic        w_dark;
    logic        w_white;
    logic [2:0]  w_code;

    assign w_pulse      = r_sens_sync & ~r_sens_prev;
    assign w_count_next = (w_pulse && (r_count != 16'hFFFF)) ? r_count + 16'd1 : r_count;

    // Widen to 32 bits so count + margin never wraps in the dominance test.
    assign w_red   = {16'b0, r_red};
    assign w_green = {16'b0, r_green};
    assign w_blue  = {16'b0, r_blue};
    assign w_dark  = (w_red < L_DARK) && (w_green < L_DARK) && (w_blue < L_DARK);
    assign w_white = (w_red > L_WHITE) && (w_green > L_WHITE) && (w_blue > L_WHITE);

    always_comb begin
        w_code = C_BIN;
        if (w_white) begin
            w_code = C_RECYCLE;
        end else if ((w_red >= w_green + L_MARGIN) && (w_red >= w_blue + L_MARGIN)) begin
            w_code = C_RED;
        end else if ((w_green >= w_red + L_MARGIN) && (w_green >= w_blue + L_MARGIN)) begin
            w_code = C_GREEN;
        end else if ((w_blue >= w_red + L_MARGIN) && (w_blue >= w_green + L_MARGIN)) begin
            w_code = C_BLUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_chan      <= 2'd0;
            r_timer     <= 32'd0;
            r_chips     <= 32'd0;
            r_count     <= 16'd0;
            r_red       <= 16'd0;
            r_green     <= 16'd0;
            r_blue      <= 16'd0;
            r_colour    <= C_IDLE;
            r_lift      <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_start     <= 1'b0;
            r_timeout   <= 1'b0;
            r_sens_meta <= 1'b0;
            r_sens_sync <= 1'b0;
            r_sens_prev <= 1'b0;
        end else begin
            r_sens_meta <= sensorOut;
            r_sens_sync <= r_sens_meta;
            r_sens_prev <= r_sens_sync;
            r_start     <= enable;

            case (r_state)
                S_IDLE: begin
                    r_colour <= C_IDLE;
                    r_lift   <= 1'b0;
                    if (enable) begin
                        r_chan  <= 2'd0;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    case (r_chan)
                        2'd0:    {r_s2, r_s3} <= 2'b00;
                        2'd1:    {r_s2, r_s3} <= 2'b11;
                        default: {r_s2, r_s3} <= 2'b01;
                    endcase
                    r_count <= 16'd0;
                    r_timer <= 32'd0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_timer == L_SETTLE_LAST) begin
                        r_timer <= 32'd0;
                        r_state <= S_GATE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_GATE: begin
                    r_count <= w_count_next;
                    if (r_timer == L_GATE_LAST) begin
                        r_timer <= 32'd0;
                        case (r_chan)
                            2'd0:    r_red   <= w_count_next;
                            2'd1:    r_green <= w_count_next;
                            default: r_blue  <= w_count_next;
                        endcase
                        if (r_chan == 2'd2) begin
                            r_state <= S_CLASSIFY;
                        end else begin
                            r_chan  <= r_chan + 2'd1;
                            r_state <= S_SELECT;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_CLASSIFY: begin
                    if (w_dark) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_colour <= w_code;
                        r_state  <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    r_timer <= 32'd0;
                    r_state <= S_ARM;
                end
                S_ARM: begin
                    // complete is ignored here: the sorter clears it late after a code change.
                    if (r_timer == 32'd1) begin
                        r_timer <= 32'd0;
                        r_state <= S_WAITDONE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_WAITDONE: begin
                    if (complete) begin
                        if (!r_lift) begin
                            r_chips <= r_chips + 32'd1;
                        end
                        r_colour <= C_IDLE;
                        r_timer  <= 32'd0;
                        r_state  <= S_RELEASE;
                    end else if (r_timer == L_TIMEOUT_LAST) begin
                        r_timeout <= 1'b1;
                        r_colour  <= C_IDLE;
                        r_timer   <= 32'd0;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_RELEASE: begin
                    if (r_timer == 32'd1) begin
                        r_timer <= 32'd0;
                        if (r_chips == L_LIFT) begin
                            r_chips  <= 32'd0;
                            r_lift   <= 1'b1;
                            r_colour <= C_LIFT;
                            r_state  <= S_DISPATCH;
                        end else begin
                            r_lift  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: begin
                    r_colour <= C_IDLE;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign s2         = r_s2;
    assign s3         = r_s3;
    assign colour     = r_colour;
    assign start      = r_start;
    assign timeoutErr = r_timeout;

endmodule

// File: tb/tb_colour_dispatch.sv
// Directed bench for colour_dispatch: red/dark/white/lift/stale-complete/timeout/reset scenarios
// with a filter-aware pulse generator and a hand-driven sorter handshake.
module tb_colour_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sensorOut;
    logic       complete;
    logic       s2;
    logic       s3;
    logic [2:0] colour;
    logic       start;
    logic       timeoutErr;

    int total = 0;
    int bad   = 0;
    int per_r = 0;
    int per_g = 0;
    int per_b = 0;
    int per   = 0;
    int ph    = 0;
    int n     = 0;

    colour_dispatch #(
        .GATE_CYCLES   (100),
        .SETTLE_CYCLES (10),
        .DARK_TH       (3),
        .WHITE_TH      (40),
        .DOM_MARGIN    (10),
        .LIFT_EVERY    (2),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sensorOut (sensorOut),
        .complete  (complete),
        .s2        (s2),
        .s3        (s3),
        .colour    (colour),
        .start     (start),
        .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    // Sensor model: square wave whose period depends on the filter currently selected.
    always @(negedge clk) begin
        case ({s2, s3})
            2'b00:   per = per_r;
            2'b11:   per = per_g;
            2'b01:   per = per_b;
            default: per = 0;
        endcase
        if (per == 0) begin
            sensorOut = 1'b0;
            ph = 0;
        end else begin
            ph = (ph + 1 >= per) ? 0 : ph + 1;
            sensorOut = (ph < per / 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_colour(input logic [2:0] want, input int budget, input string tag);
        n = 0;
        while (colour !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(colour), 32'(want));
    endtask

    task automatic hold_check(input logic [2:0] want, input int cycles, input string tag);
        logic [2:0] seen;
        seen = want;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (colour !== want) seen = colour;
        end
        chk(tag, 32'(seen), 32'(want));
    endtask

    task automatic pulse_enable(input string tag);
        enable = 1'b1;
        chk({tag, "_start_lo"}, 32'(start), 32'd0);
        @(negedge clk);
        chk({tag, "_start_hi"}, 32'(start), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk({tag, "_start_off"}, 32'(start), 32'd0);
    endtask

    task automatic set_periods(input int r, input int g, input int b);
        per_r = r;
        per_g = g;
        per_b = b;
    endtask

    // Sorter finishes after delay cycles; complete held until the controller releases.
    task automatic sort_chip(input int delay, input string tag);
        repeat (delay) @(negedge clk);
        complete = 1'b1;
        wait_colour(3'b111, 10, {tag, "_release"});
        complete = 1'b0;
    endtask

    task automatic release_tail(input logic [2:0] next, input string tag);
        @(negedge clk);
        chk({tag, "_rel2"}, 32'(colour), 32'd7);
        @(negedge clk);
        chk({tag, "_after"}, 32'(colour), 32'(next));
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        complete = 1'b0;
        sensorOut = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_colour", 32'(colour), 32'd7);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_s2s3", {30'd0, s2, s3}, 32'd0);
        chk("rst_tmo", 32'(timeoutErr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Red chip: chips=1, no lift afterwards.
        set_periods(4, 20, 20);
        pulse_enable("red");
        wait_colour(3'b000, 800, "red_code");
        sort_chip(50, "red");
        release_tail(3'b111, "red");
        hold_check(3'b111, 20, "red_idle");

        // Dark: nothing dispatched.
        set_periods(0, 0, 0);
        pulse_enable("dark");
        hold_check(3'b111, 450, "dark_hold");

        // White: recycle, second chip so a lift follows.
        set_periods(2, 2, 2);
        pulse_enable("white");
        wait_colour(3'b100, 800, "white_code");
        sort_chip(50, "white");
        release_tail(3'b101, "white");
        sort_chip(50, "lift1");
        release_tail(3'b111, "lift1");
        hold_check(3'b111, 20, "lift1_idle");

        // Two greens: 001,111,001,111,101,111.
        set_periods(20, 4, 20);
        pulse_enable("grn1");
        wait_colour(3'b001, 800, "grn1_code");
        sort_chip(50, "grn1");
        release_tail(3'b111, "grn1");
        pulse_enable("grn2");
        wait_colour(3'b001, 800, "grn2_code");
        sort_chip(50, "grn2");
        release_tail(3'b101, "grn2");
        sort_chip(50, "lift2");
        release_tail(3'b111, "lift2");
        hold_check(3'b111, 20, "lift2_idle");

        // Stale complete: high for the first 2 code cycles, must be ignored.
        set_periods(10, 10, 10);
        pulse_enable("bin");
        complete = 1'b1;
        wait_colour(3'b011, 800, "bin_code");
        @(negedge clk);
        @(negedge clk);
        complete = 1'b0;
        hold_check(3'b011, 30, "stale_hold");
        sort_chip(20, "bin");
        release_tail(3'b111, "bin");
        hold_check(3'b111, 20, "bin_idle");

        // Timeout on a red chip, with filter sequencing observed on the way.
        set_periods(4, 20, 20);
        pulse_enable("tmo");
        repeat (50) @(negedge clk);
        chk("filter_red", {30'd0, s2, s3}, 32'd0);
        repeat (120) @(negedge clk);
        chk("filter_green", {30'd0, s2, s3}, 32'd3);
        repeat (110) @(negedge clk);
        chk("filter_blue", {30'd0, s2, s3}, 32'd1);
        wait_colour(3'b000, 300, "tmo_code");
        chk("tmo_pre", 32'(timeoutErr), 32'd0);
        n = 0;
        while (timeoutErr !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_flag", 32'(timeoutErr), 32'd1);
        chk("tmo_latency", 32'(n >= 998 && n <= 1008), 32'd1);
        chk("tmo_colour", 32'(colour), 32'd7);
        hold_check(3'b111, 10, "tmo_idle");
        chk("tmo_sticky", 32'(timeoutErr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_colour", 32'(colour), 32'd7);
        chk("rst2_start", 32'(start), 32'd0);
        chk("rst2_s2s3", {30'd0, s2, s3}, 32'd0);
        chk("rst2_tmo", 32'(timeoutErr), 32'd0);

        // Reset while waiting for complete: dispatch abandoned.
        set_periods(20, 4, 20);
        pulse_enable("abort");
        wait_colour(3'b001, 800, "abort_code");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_colour", 32'(colour), 32'd7);
        complete = 1'b1;
        hold_check(3'b111, 100, "abort_hold");
        complete = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
